// File: rtl/ub_ctrl_pkg.sv
// Shared types and default widths for the unified-buffer affine control generator.
//   state_e     : generator FSM states
//   ctrl_vars_t : one loop index / extent value
package ub_ctrl_pkg;

  localparam int unsigned NUM_DIMS = 3;   // loop depth, index 0 outermost
  localparam int unsigned CW       = 16;  // ctrl_var / extent width
  localparam int unsigned DLY_W    = 32;  // schedule-delay counter width
  localparam int unsigned II_W     = 8;   // initiation-interval width
  localparam int unsigned AW       = 16;  // linear address width

  typedef enum logic [1:0] {
    StIdle,
    StDelay,
    StRun,
    StDone
  } state_e;

  typedef logic [CW-1:0] ctrl_vars_t;

endpackage

// File: rtl/ub_affine_ctrl_gen_if.sv
// Strobe/index bus from the affine control generator to a *_stencil_ub port.
//   en        : wen/ren strobe
//   ctrl_vars : loop indices, valid while en=1, held otherwise
//   busy      : frame in progress
//   done      : frame complete, held until next flush
//   addr      : linear address aligned with en (only with UB_CTRL_ADDR_EN)
// Modports: master (generator), slave (buffer port).
interface ub_affine_ctrl_gen_if;
  import ub_ctrl_pkg::*;

  logic       en;
  ctrl_vars_t ctrl_vars [NUM_DIMS-1:0];
  logic       busy;
  logic       done;
`ifdef UB_CTRL_ADDR_EN
  logic [AW-1:0] addr;

  modport master (output en, ctrl_vars, busy, done, addr);
  modport slave  (input  en, ctrl_vars, busy, done, addr);
`else
  modport master (output en, ctrl_vars, busy, done);
  modport slave  (input  en, ctrl_vars, busy, done);
`endif

endinterface

// File: rtl/ub_ctrl_dim_cnt.sv
// One loop-dimension counter of the affine control generator.
//   clr       : synchronous zero (highest priority)
//   inc_in    : advance by one this cycle
//   extent    : trip count of this dimension
//   value     : registered index
//   value_nxt : next-state index (only with UB_CTRL_ADDR_EN, feeds the address register)
//   wrap      : value is at extent-1; an increment now wraps and carries outward
module ub_ctrl_dim_cnt
  import ub_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc_in,
  input  ctrl_vars_t extent,
  output ctrl_vars_t value,
`ifdef UB_CTRL_ADDR_EN
  output ctrl_vars_t value_nxt,
`endif
  output logic       wrap
);

  ctrl_vars_t value_q, value_d;

  assign wrap = (value_q == extent - ctrl_vars_t'(1));

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc_in) begin
      value_d = wrap ? '0 : value_q + ctrl_vars_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) value_q <= '0;
    else        value_q <= value_d;
  end

  assign value = value_q;
`ifdef UB_CTRL_ADDR_EN
  assign value_nxt = value_d;
`endif

endmodule

// File: rtl/ub_affine_ctrl_gen.sv
// Affine control generator: after cfg_delay cycles, walks a NUM_DIMS-deep rectangular loop
// nest (innermost fastest), one strobe every max(cfg_ii,1) cycles, then raises done.
//   clk, rst_n  : clock, async active-low reset
//   flush       : start/restart pulse, samples all cfg_* inputs
//   cfg_extent  : trip count per dimension
//   cfg_delay   : cycles from flush to first strobe
//   cfg_ii      : cycles between strobes (0 behaves as 1)
//   cfg_stride,
//   cfg_offset  : address generation terms (only with UB_CTRL_ADDR_EN)
//   ub          : strobe/index bus (master side)
// Optional feature macro: UB_CTRL_ADDR_EN adds the registered linear address output.
module ub_affine_ctrl_gen
  import ub_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  ctrl_vars_t           cfg_extent [NUM_DIMS-1:0],
  input  logic [DLY_W-1:0]     cfg_delay,
  input  logic [II_W-1:0]      cfg_ii,
`ifdef UB_CTRL_ADDR_EN
  input  logic [AW-1:0]        cfg_stride [NUM_DIMS-1:0],
  input  logic [AW-1:0]        cfg_offset,
`endif
  ub_affine_ctrl_gen_if.master ub
);

  state_e           state_q, state_d;
  ctrl_vars_t       ext_q [NUM_DIMS-1:0];
  logic [DLY_W-1:0] dly_q, dly_cnt_q, dly_cnt_d;
  logic [II_W-1:0]  ii_q, ii_cnt_q, ii_cnt_d, ii_max, ii_nxt;
  logic             en_q, en_d;
  logic             clr, step, launch, any_zero, all_last;
  logic [NUM_DIMS-1:0] wrap;
  ctrl_vars_t       vars [NUM_DIMS-1:0];

  // Extents are taken from the inputs in the flush cycle so a zero-delay launch sees them.
  always_comb begin
    any_zero = 1'b0;
    for (int d = 0; d < NUM_DIMS; d++) begin
      if ((flush ? cfg_extent[d] : ext_q[d]) == '0) any_zero = 1'b1;
    end
  end

  assign all_last = &wrap;
  assign ii_max   = (ii_q == '0) ? '0 : ii_q - II_W'(1);
  assign ii_nxt   = (ii_cnt_q == ii_max) ? '0 : ii_cnt_q + II_W'(1);

  // dly_cnt_q counts cycles since flush starting at 1, so the launch edge makes the first
  // strobe visible exactly cfg_delay+1 cycles after the flush cycle.
  assign launch = flush ? (cfg_delay == '0)
                        : ((state_q == StDelay) && (dly_cnt_q == dly_q));

  always_comb begin
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    ii_cnt_d  = ii_cnt_q;
    en_d      = 1'b0;
    clr       = 1'b0;
    step      = 1'b0;

    if (flush) begin
      state_d   = StDelay;
      dly_cnt_d = DLY_W'(1);
      ii_cnt_d  = '0;
      clr       = 1'b1;
    end else begin
      unique case (state_q)
        StDelay: dly_cnt_d = dly_cnt_q + DLY_W'(1);
        StRun: begin
          if (en_q && all_last) begin
            state_d = StDone;
          end else begin
            ii_cnt_d = ii_nxt;
            if (ii_nxt == '0) begin
              en_d = 1'b1;
              step = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    // First strobe presents the all-zero iteration, so the counters are not stepped here.
    if (launch) begin
      ii_cnt_d = '0;
      if (any_zero) begin
        state_d = StDone;
      end else begin
        state_d = StRun;
        en_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      dly_cnt_q <= '0;
      ii_cnt_q  <= '0;
      en_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_cnt_q <= dly_cnt_d;
      ii_cnt_q  <= ii_cnt_d;
      en_q      <= en_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q <= '0;
      ii_q  <= '0;
      for (int d = 0; d < NUM_DIMS; d++) ext_q[d] <= '0;
    end else if (flush) begin
      dly_q <= cfg_delay;
      ii_q  <= cfg_ii;
      for (int d = 0; d < NUM_DIMS; d++) ext_q[d] <= cfg_extent[d];
    end
  end

`ifdef UB_CTRL_ADDR_EN
  ctrl_vars_t    vars_nxt [NUM_DIMS-1:0];
  logic [AW-1:0] stride_q [NUM_DIMS-1:0];
  logic [AW-1:0] off_q, addr_q, addr_d;
`endif

  for (genvar d = 0; d < NUM_DIMS; d++) begin : g_dim
    logic inc;
    if (d == NUM_DIMS - 1) begin : g_inner
      assign inc = step;
    end else begin : g_outer
      // Carry ripples in only when every inner dimension wraps.
      assign inc = step & (&wrap[NUM_DIMS-1:d+1]);
    end

    ub_ctrl_dim_cnt u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (clr),
      .inc_in    (inc),
      .extent    (ext_q[d]),
      .value     (vars[d]),
`ifdef UB_CTRL_ADDR_EN
      .value_nxt (vars_nxt[d]),
`endif
      .wrap      (wrap[d])
    );
  end

`ifdef UB_CTRL_ADDR_EN
  // Computed from next-state indices so the registered address lines up with en.
  always_comb begin
    addr_d = flush ? cfg_offset : off_q;
    for (int d = 0; d < NUM_DIMS; d++) begin
      addr_d = addr_d + (flush ? cfg_stride[d] : stride_q[d]) * AW'(vars_nxt[d]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      off_q  <= '0;
      addr_q <= '0;
      for (int d = 0; d < NUM_DIMS; d++) stride_q[d] <= '0;
    end else begin
      addr_q <= addr_d;
      if (flush) begin
        off_q <= cfg_offset;
        for (int d = 0; d < NUM_DIMS; d++) stride_q[d] <= cfg_stride[d];
      end
    end
  end

  assign ub.addr = addr_q;
`endif

  assign ub.en        = en_q;
  assign ub.ctrl_vars = vars;
  assign ub.busy      = (state_q == StDelay) || (state_q == StRun);
  assign ub.done      = (state_q == StDone);

endmodule

// File: tb/tb_ub_affine_ctrl_gen.sv
// Self-checking bench for ub_affine_ctrl_gen: table of frame configurations with hand-computed
// strobe counts and done cycles, plus re-flush and mid-frame reset sequences.
module tb_ub_affine_ctrl_gen;
  import ub_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  ctrl_vars_t       cfg_extent [NUM_DIMS-1:0];
  logic [DLY_W-1:0] cfg_delay;
  logic [II_W-1:0]  cfg_ii;
`ifdef UB_CTRL_ADDR_EN
  logic [AW-1:0]    cfg_stride [NUM_DIMS-1:0];
  logic [AW-1:0]    cfg_offset;
`endif

  ub_affine_ctrl_gen_if ub ();

  ub_affine_ctrl_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .cfg_extent (cfg_extent),
    .cfg_delay  (cfg_delay),
    .cfg_ii     (cfg_ii),
`ifdef UB_CTRL_ADDR_EN
    .cfg_stride (cfg_stride),
    .cfg_offset (cfg_offset),
`endif
    .ub         (ub)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int e0, e1, e2;   // extents, e0 outermost
    int dly;
    int ii;
    int total;        // expected number of strobes
    int done_cyc;     // first cycle with done=1 (flush cycle is 0)
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " en"},   ub.en,   1'b0);
    chk({tag, " busy"}, ub.busy, 1'b0);
    chk({tag, " done"}, ub.done, 1'b0);
    for (int d = 0; d < NUM_DIMS; d++)
      chk($sformatf("%s v%0d", tag, d), ub.ctrl_vars[d], '0);
  endtask

  // Flushes in the current cycle (cycle 0), then checks cycles 1..min(max_cyc, done_cyc+2).
  task automatic run_frame(input vec_t v, input int max_cyc, input string tag);
    int         iie, first, last, n;
    logic       exp_en, exp_done;
    ctrl_vars_t hv [3];
    cfg_extent[0] = CW'(v.e0);
    cfg_extent[1] = CW'(v.e1);
    cfg_extent[2] = CW'(v.e2);
    cfg_delay     = DLY_W'(v.dly);
    cfg_ii        = II_W'(v.ii);
    flush         = 1'b1;
    iie   = (v.ii == 0) ? 1 : v.ii;
    first = 1 + v.dly;
    last  = v.done_cyc + 2;
    if (max_cyc < last) last = max_cyc;
    for (int i = 0; i < 3; i++) hv[i] = '0;
    for (int cyc = 1; cyc <= last; cyc++) begin
      tick();
      if (cyc == 1) flush = 1'b0;
      exp_en = (cyc >= first) && ((cyc - first) % iie == 0) && ((cyc - first) / iie < v.total);
      if (exp_en) begin
        n     = (cyc - first) / iie;
        hv[2] = CW'(n % v.e2);
        hv[1] = CW'((n / v.e2) % v.e1);
        hv[0] = CW'(n / (v.e2 * v.e1));
      end
      exp_done = (cyc >= v.done_cyc);
      chk($sformatf("%s c%0d en", tag, cyc),   ub.en,   exp_en);
      chk($sformatf("%s c%0d done", tag, cyc), ub.done, exp_done);
      chk($sformatf("%s c%0d busy", tag, cyc), ub.busy, !exp_done);
      for (int d = 0; d < NUM_DIMS; d++)
        chk($sformatf("%s c%0d v%0d", tag, cyc, d), ub.ctrl_vars[d], hv[d]);
`ifdef UB_CTRL_ADDR_EN
      if (exp_en)
        chk($sformatf("%s c%0d addr", tag, cyc), ub.addr,
            AW'(cfg_offset + cfg_stride[0] * hv[0] + cfg_stride[1] * hv[1]
                + cfg_stride[2] * hv[2]));
`endif
    end
  endtask

  initial begin
    vecs[0] = '{2, 3, 4, 5, 1, 24, 30};
    vecs[1] = '{1, 1, 3, 0, 3, 3, 8};
    vecs[2] = '{62, 62, 0, 4, 1, 0, 5};
    vecs[3] = '{1, 1, 1, 0, 0, 1, 2};
    vecs[4] = '{2, 1, 2, 2, 2, 4, 10};
    vecs[5] = '{0, 5, 5, 0, 1, 0, 1};

    rst_n     = 1'b0;
    flush     = 1'b0;
    cfg_delay = '0;
    cfg_ii    = '0;
    for (int d = 0; d < NUM_DIMS; d++) cfg_extent[d] = '0;
`ifdef UB_CTRL_ADDR_EN
    cfg_stride[0] = AW'(3);
    cfg_stride[1] = AW'(5);
    cfg_stride[2] = AW'(7);
    cfg_offset    = AW'(100);
`endif

    #12;
    chk_idle("reset");
`ifdef UB_CTRL_ADDR_EN
    chk("reset addr", ub.addr, '0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle($sformatf("idle%0d", i));
    end

    foreach (vecs[i]) run_frame(vecs[i], 100000, $sformatf("vec%0d", i));

    // Restart after 10 strobes (strobes at cycles 6..15), then a full frame from that flush.
    run_frame(vecs[0], 15, "rf_a");
    run_frame(vecs[0], 100000, "rf_b");

    // Asynchronous reset mid-RUN with non-zero indices (strobe 4 -> 0,1,0 at cycle 5).
    run_frame('{2, 3, 4, 0, 1, 24, 25}, 5, "rst_a");
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("rst_async");
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_idle($sformatf("rst_hold%0d", i));
    end
    run_frame(vecs[1], 100000, "rst_b");

`ifdef UB_CTRL_ADDR_EN
    cfg_stride[0] = AW'(0);
    cfg_stride[1] = AW'(62);
    cfg_stride[2] = AW'(1);
    cfg_offset    = AW'(0);
    run_frame('{1, 62, 62, 0, 1, 3844, 3845}, 100000, "addr");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
